mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single DRAM memory-bus slave between NUM_REQ requesters (core/cache bus masters).
- Round-robin grants one packet at a time and forwards it downstream with a source ID.
- For reads, holds the bus until the read response returns, then routes the response to the originating requester.
- At most one transaction is outstanding at any time.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- ADDR_W, 64, bus address width
- DATA_W, 64, payload width (bus_packet_payload_t)
- SRC_W, 3, source-ID width; must satisfy 2**SRC_W >= NUM_REQ
- TIMEOUT_CYC, 1024, read-response watchdog limit (only with the optional feature)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_type  in  NUM_REQ*2  per-requester bus_packet_type_t
- req_addr  in  NUM_REQ*ADDR_W  per-requester address
- req_payload  in  NUM_REQ*DATA_W  per-requester write data
- mem_valid  out  1  downstream request valid
- mem_ready  in  1  downstream accept (DRAM not busy)
- mem_type  out  2  forwarded packet type
- mem_addr  out  ADDR_W  forwarded address
- mem_payload  out  DATA_W  forwarded write data
- mem_source  out  SRC_W  index of the granted requester
- rsp_in_valid  in  1  DRAM read response valid
- rsp_in_data  in  DATA_W  DRAM read data
- rsp_in_dest  in  SRC_W  response destination ID
- rsp_valid  out  NUM_REQ  per-requester response strobe, one-hot
- rsp_data  out  DATA_W  response data, shared by all requesters
- err_unknown  out  1  one-cycle pulse when a request carries an unrecognized packet type
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; rr pointer=0; all internal registers cleared.
- Handshake: a transfer occurs on a cycle where valid && ready. Requesters hold req_* stable until req_ready.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - If any req_valid is set, pick the winner round-robin, starting from the pointer.
  - Assert req_ready[winner] for exactly 1 cycle and latch its type, addr, payload and source.
  - Update pointer to winner+1, wrapping to 0 at NUM_REQ. Go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- Unrecognized type (not bus_read_data or bus_write_data): accept the request, pulse err_unknown, do not forward, stay in IDLE.
- ISSUE:
  - Drive mem_valid=1 with the latched fields until mem_ready. Fields are stable while mem_valid=1.
  - On transfer of a write: go to IDLE. Writes are posted and produce no response.
  - On transfer of a read: go to WAIT_RSP.
- WAIT_RSP:
  - On rsp_in_valid with rsp_in_dest equal to the latched source: register the response.
  - Next cycle: rsp_valid[source]=1 for 1 cycle and rsp_data=rsp_in_data; return to IDLE.
  - rsp_in_valid with any other dest is ignored. This is a verification error; the bench asserts it never happens.
- Latency: request accept -> mem_valid is 1 cycle. Response in -> rsp_valid is 1 cycle. The next grant can be issued in the cycle after returning to IDLE.
- Minimum occupancy per transaction, assuming mem_ready is already high:
  - write: 2 cycles
  - read: 3 cycles + DRAM latency
- Simultaneous requests: exactly one grant per IDLE cycle; the others keep waiting. No requester starves: worst-case wait is NUM_REQ-1 transactions.
- rsp_in_valid outside WAIT_RSP is ignored.
- reset_n asserted mid-transaction: the transaction is dropped and no response is delivered. Requesters must re-issue after reset.
- Pointer wrap: when the winner is NUM_REQ-1, the pointer becomes 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT_RSP and increments each cycle in WAIT_RSP.
  - When it reaches TIMEOUT_CYC: rsp_valid[source] pulses with rsp_data=0, output err_timeout (extra 1-bit port) pulses for 1 cycle, and the state returns to IDLE.
  - A late response after the timeout is ignored.
- Undefined: no counter and no err_timeout port; WAIT_RSP waits indefinitely.

Decomposition:
- Shared package (memory-bus package): bus_packet_type_t enum (bus_read_data, bus_write_data), bus_packet_payload_t, the ADDR_W/DATA_W/SRC_W defaults, and arb_state_t.
- Sub-module rr_arbiter: NUM_REQ request vector plus pointer in; one-hot grant and encoded index out; purely combinational.

Test Plan:
- Single read: req_valid[2] with read at addr 0x100; DRAM returns 0x1122334455667788 -> mem_source=2; rsp_valid=4'b0100, rsp_data=0x1122334455667788 one cycle after the response.
- Single write: req_valid[0] with write at addr 0x40, payload 0xDEADBEEF -> one mem transfer; no rsp_valid; busy low 2 cycles after accept.
- All four requesters hold valid continuously with writes -> grant order 0,1,2,3,0,1; each req_ready is a 1-cycle pulse.
- Backpressure: mem_ready=0 for 5 cycles during ISSUE -> mem_valid and fields stay stable; no new req_ready until the transfer completes.
- Reset asserted while in WAIT_RSP -> all outputs 0 immediately; a DRAM response arriving after reset produces no rsp_valid.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, a read with no response -> after 16 cycles err_timeout=1 and rsp_valid[src] with data 0; a late response is ignored.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared memory-bus definitions: packet type encoding, payload type,
//   default bus widths and the arbiter state encoding.
//   Also provides is_known_type(), which tells the two forwarded packet
//   types apart from any other 2-bit code.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;
    localparam int SRC_W_DEF  = 3;

    typedef enum logic [1:0] {
        bus_read_data  = 2'd0,
        bus_write_data = 2'd1
    } bus_packet_type_t;

    typedef logic [DATA_W_DEF-1:0] bus_packet_payload_t;

    typedef enum logic [1:0] {
        arb_idle     = 2'd0,
        arb_issue    = 2'd1,
        arb_wait_rsp = 2'd2
    } arb_state_t;

    function automatic logic is_known_type(input logic [1:0] t);
        return (t == bus_read_data) || (t == bus_write_data);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick. The search starts at ptr and
//   wraps at NUM_REQ; the first set request bit wins.
//   Ports:
//     req    in   NUM_REQ  request vector
//     ptr    in   IDX_W    index with highest priority this cycle (< NUM_REQ)
//     grant  out  NUM_REQ  one-hot grant, zero when no request
//     idx    out  IDX_W    encoded index of the grant
//     valid  out  1        at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Outer loop walks priority order (offset from ptr), inner loop finds
    // the requester sitting at that offset.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i] && (i == ((int'(ptr) + off) % NUM_REQ))) begin
                    valid    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one DRAM bus slave between NUM_REQ bus masters. One packet at a
//   time is granted round-robin, forwarded with its source ID, and for reads
//   the bus is held until the matching response is routed back.
//   Optional build macro MEM_ARB_TIMEOUT_EN adds a read-response watchdog
//   (parameter TIMEOUT_CYC, output err_timeout).
//   Ports:
//     clk, reset_n                        clock, async active-low reset
//     req_valid/ready/type/addr/payload   per-requester request channel
//     mem_valid/ready/type/addr/payload   downstream request channel
//     mem_source                          granted requester index
//     rsp_in_valid/data/dest              DRAM read response
//     rsp_valid, rsp_data                 routed response (one-hot strobe)
//     err_unknown                         pulse on unrecognized packet type
//     busy                                not idle
//     err_timeout                         (macro only) watchdog pulse
//
//   state        | meaning
//   arb_idle     | waiting for a request; grants one per cycle
//   arb_issue    | latched packet offered downstream until mem_ready
//   arb_wait_rsp | read issued, waiting for the response for src_q
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SRC_W       = SRC_W_DEF
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*2-1:0]      req_type,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_payload,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [1:0]                mem_type,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_payload,
    output logic [SRC_W-1:0]          mem_source,
    input  logic                      rsp_in_valid,
    input  logic [DATA_W-1:0]         rsp_in_data,
    input  logic [SRC_W-1:0]          rsp_in_dest,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      err_unknown,
    output logic                      busy
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                      err_timeout
`endif
);

    arb_state_t          state_q, state_d;
    logic [SRC_W-1:0]    ptr_q;
    // Low during reset and for the first cycle after it, so req_ready
    // stays zero while reset_n is asserted even if requesters are valid.
    logic                armed_q;

    logic [NUM_REQ-1:0]  grant;
    logic [SRC_W-1:0]    win_idx;
    logic                any_req;
    logic [1:0]          win_type;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_payload;
    logic                win_known;

    logic [1:0]          type_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   payload_q;
    logic [SRC_W-1:0]    src_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                err_unknown_q;
    logic [NUM_REQ-1:0]  src_onehot;

    logic                accept;
    logic                rsp_hit;
    logic                tmo_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .valid (any_req)
    );

    always_comb begin
        win_type    = '0;
        win_addr    = '0;
        win_payload = '0;
        src_onehot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_type    = req_type[i*2 +: 2];
                win_addr    = req_addr[i*ADDR_W +: ADDR_W];
                win_payload = req_payload[i*DATA_W +: DATA_W];
            end
            src_onehot[i] = (src_q == SRC_W'(i));
        end
    end

    assign win_known = is_known_type(win_type);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_timeout_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= arb_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rsp_hit = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            arb_idle: begin
                if (armed_q && any_req) begin
                    accept = 1'b1;
                    // Unknown types are consumed here and never forwarded.
                    if (win_known) begin
                        state_d = arb_issue;
                    end
                end
            end
            arb_issue: begin
                if (mem_ready) begin
                    state_d = (type_q == bus_read_data) ? arb_wait_rsp : arb_idle;
                end
            end
            arb_wait_rsp: begin
                if (rsp_in_valid && (rsp_in_dest == src_q)) begin
                    rsp_hit = 1'b1;
                    state_d = arb_idle;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = arb_idle;
                end
`endif
            end
            default: state_d = arb_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= '0;
            armed_q       <= 1'b0;
            type_q        <= '0;
            addr_q        <= '0;
            payload_q     <= '0;
            src_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            err_unknown_q <= 1'b0;
        end else begin
            armed_q       <= 1'b1;
            rsp_valid_q   <= '0;
            err_unknown_q <= accept && !win_known;
            if (accept) begin
                ptr_q <= (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                if (win_known) begin
                    type_q    <= win_type;
                    addr_q    <= win_addr;
                    payload_q <= win_payload;
                    src_q     <= win_idx;
                end
            end
            if (rsp_hit) begin
                rsp_valid_q <= src_onehot;
                rsp_data_q  <= rsp_in_data;
            end else if (tmo_hit) begin
                rsp_valid_q <= src_onehot;
                rsp_data_q  <= '0;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= tmo_hit;
            if (state_q != arb_wait_rsp) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign err_timeout = err_timeout_q;
`endif

    assign req_ready   = accept ? grant : '0;
    assign mem_valid   = (state_q == arb_issue);
    assign mem_type    = type_q;
    assign mem_addr    = addr_q;
    assign mem_payload = payload_q;
    assign mem_source  = src_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign err_unknown = err_unknown_q;
    assign busy        = (state_q != arb_idle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter with NUM_REQ=4 and default widths.
//   With MEM_ARB_TIMEOUT_EN defined it also exercises the watchdog with
//   TIMEOUT_CYC=16.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*2-1:0]  req_type;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_payload;
    logic            mem_valid;
    logic            mem_ready;
    logic [1:0]      mem_type;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_payload;
    logic [SW-1:0]   mem_source;
    logic            rsp_in_valid;
    logic [DW-1:0]   rsp_in_data;
    logic [SW-1:0]   rsp_in_dest;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            err_unknown;
    logic            busy;
`ifdef MEM_ARB_TIMEOUT_EN
    logic            err_timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SRC_W       (SW)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_type     (req_type),
        .req_addr     (req_addr),
        .req_payload  (req_payload),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_type     (mem_type),
        .mem_addr     (mem_addr),
        .mem_payload  (mem_payload),
        .mem_source   (mem_source),
        .rsp_in_valid (rsp_in_valid),
        .rsp_in_data  (rsp_in_data),
        .rsp_in_dest  (rsp_in_dest),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .err_unknown  (err_unknown),
        .busy         (busy)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .err_timeout  (err_timeout)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] t,
                           input logic [AW-1:0] a, input logic [DW-1:0] p);
        req_valid[i]           = v;
        req_type[i*2 +: 2]     = t;
        req_addr[i*AW +: AW]   = a;
        req_payload[i*DW +: DW] = p;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_memv"},  64'(mem_valid), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_rspv"},  64'(rsp_valid), 64'd0);
        chk({tag, "_maddr"}, mem_addr, 64'd0);
        chk({tag, "_msrc"},  64'(mem_source), 64'd0);
    endtask

    // The bench never sends a response to a requester other than the one
    // holding the bus.
    always @(negedge clk) begin
        if (reset_n && rsp_in_valid && busy && !mem_valid)
            chk("rsp_dest_match", 64'(rsp_in_dest), 64'(mem_source));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset_n      = 1'b0;
        req_valid    = '0;
        req_type     = '0;
        req_addr     = '0;
        req_payload  = '0;
        mem_ready    = 1'b1;
        rsp_in_valid = 1'b0;
        rsp_in_data  = '0;
        rsp_in_dest  = '0;

        // Reset state, with a request pending during reset
        set_req(1, 1'b1, bus_write_data, 64'h80, 64'h1);
        #3;
        chk_all_zero("reset");
        step();
        chk_all_zero("reset_clk");
        req_valid = '0;
        reset_n = 1'b1;
        step();

        // Stray response in IDLE is ignored
        rsp_in_valid = 1'b1; rsp_in_dest = 3'd0; rsp_in_data = 64'hABCD;
        step();
        rsp_in_valid = 1'b0;
        chk("idle_rsp_ignored", 64'(rsp_valid), 64'd0);

        // Single read from requester 2
        set_req(2, 1'b1, bus_read_data, 64'h100, 64'h0);
        #1;
        chk("rd_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid[2] = 1'b0;
        #1;
        chk("rd_memv", 64'(mem_valid), 64'd1);
        chk("rd_src", 64'(mem_source), 64'd2);
        chk("rd_addr", mem_addr, 64'h100);
        chk("rd_type", 64'(mem_type), 64'(bus_read_data));
        chk("rd_ready_off", 64'(req_ready), 64'd0);
        step();
        chk("rd_wait_memv", 64'(mem_valid), 64'd0);
        chk("rd_wait_busy", 64'(busy), 64'd1);
        step();
        rsp_in_valid = 1'b1; rsp_in_dest = 3'd2; rsp_in_data = 64'h1122334455667788;
        step();
        rsp_in_valid = 1'b0;
        chk("rd_rspv", 64'(rsp_valid), 64'b0100);
        chk("rd_rspd", rsp_data, 64'h1122334455667788);
        chk("rd_idle", 64'(busy), 64'd0);
        step();
        chk("rd_rspv_pulse", 64'(rsp_valid), 64'd0);

        // Single write from requester 0
        set_req(0, 1'b1, bus_write_data, 64'h40, 64'hDEADBEEF);
        #1;
        chk("wr_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid[0] = 1'b0;
        chk("wr_memv", 64'(mem_valid), 64'd1);
        chk("wr_type", 64'(mem_type), 64'(bus_write_data));
        chk("wr_payload", mem_payload, 64'hDEADBEEF);
        chk("wr_addr", mem_addr, 64'h40);
        chk("wr_src", 64'(mem_source), 64'd0);
        step();
        chk("wr_busy_low", 64'(busy), 64'd0);
        chk("wr_memv_low", 64'(mem_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
        end

        // Round-robin from a fresh pointer with everyone requesting
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        step();
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, bus_write_data, 64'(32'h1000 + i * 16), 64'(i));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(1 << (k % N)));
            step();
            chk("rr_pulse", 64'(req_ready), 64'd0);
            chk("rr_src", 64'(mem_source), 64'(k % N));
            chk("rr_addr", mem_addr, 64'(32'h1000 + (k % N) * 16));
            step();
        end
        req_valid = '0;

        // Backpressure: pointer is now 2, so requester 3 wins over 1
        mem_ready = 1'b0;
        set_req(3, 1'b1, bus_write_data, 64'h2000, 64'h55AA);
        set_req(1, 1'b1, bus_read_data, 64'h300, 64'h0);
        #1;
        chk("bp_grant", 64'(req_ready), 64'b1000);
        step();
        req_valid[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_memv", 64'(mem_valid), 64'd1);
            chk("bp_addr", mem_addr, 64'h2000);
            chk("bp_payload", mem_payload, 64'h55AA);
            chk("bp_src", 64'(mem_source), 64'd3);
            chk("bp_no_ready", 64'(req_ready), 64'd0);
            step();
        end
        mem_ready = 1'b1;
        step();
        #1;
        chk("bp_next_grant", 64'(req_ready), 64'b0010);

        // Reset while waiting for a read response
        step();
        req_valid[1] = 1'b0;
        chk("rst_rd_src", 64'(mem_source), 64'd1);
        step();
        chk("rst_in_wait", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        #2;
        reset_n = 1'b1;
        rsp_in_valid = 1'b1; rsp_in_dest = 3'd1; rsp_in_data = 64'h77;
        step();
        rsp_in_valid = 1'b0;
        chk("rst_late_rspv", 64'(rsp_valid), 64'd0);
        step();
        chk("rst_late_rspv2", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Unknown packet type is consumed, flagged and not forwarded
        set_req(2, 1'b1, 2'b11, 64'h500, 64'h9);
        #1;
        chk("unk_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid[2] = 1'b0;
        chk("unk_err", 64'(err_unknown), 64'd1);
        chk("unk_memv", 64'(mem_valid), 64'd0);
        chk("unk_busy", 64'(busy), 64'd0);
        step();
        chk("unk_err_pulse", 64'(err_unknown), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Read with no response: watchdog fires 16 cycles into WAIT_RSP
        begin
            int cyc;
            cyc = 0;
            set_req(0, 1'b1, bus_read_data, 64'h600, 64'h0);
            step();
            req_valid[0] = 1'b0;
            step();
            while (!err_timeout && cyc < 100) begin
                step();
                cyc++;
            end
            chk("tmo_cycles", 64'(cyc), 64'd16);
            chk("tmo_rspv", 64'(rsp_valid), 64'b0001);
            chk("tmo_rspd", rsp_data, 64'd0);
            rsp_in_valid = 1'b1; rsp_in_dest = 3'd0; rsp_in_data = 64'hFEED;
            step();
            rsp_in_valid = 1'b0;
            chk("tmo_err_pulse", 64'(err_timeout), 64'd0);
            chk("tmo_late_rspv", 64'(rsp_valid), 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
